tmp_meas_seq: RTL
=================

TMP_MEAS_SEQ -- requirements
Module: tmp_meas_seq

Interface
REQ-001 Parameter: SETTLE, default 12, number of core warm-up cycles after core_rst release before counting starts.
REQ-002 Parameter: WIN, default 255, measurement window length in clk cycles (1..65535).
REQ-003 Parameter: CNT_W, default 8, width of the event counter and result.
REQ-004 Port: clk  input  1  rising-edge clock shared with the sensor core.
REQ-005 Port: reset  input  1  reset, asynchronous, active-high.
REQ-006 Port: start  input  1  single-cycle request to begin a measurement; sampled only in IDLE.
REQ-007 Port: cont  input  1  continuous mode; when high, a new window starts after each accepted result.
REQ-008 Port: src_ev  input  1  single-cycle pulse from the core for each source decision (comparator high), already synchronous to clk.
REQ-009 Port: snk_ev  input  1  single-cycle pulse from the core for each sink decision (comparator low), synchronous.
REQ-010 Port: core_rst  output  1  holds the sensor core in reset/precharge while high.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: result  output  CNT_W  src_ev count of the completed window, saturated.
REQ-013 Port: result_valid  output  1  result is held stable while high.
REQ-014 Port: result_ready  input  1  consumer accepts result when result_valid and result_ready are both high on a rising edge.
REQ-015 Port: ovf  output  1  sticky flag, set when any counter saturates; cleared only by a start accepted in IDLE, or by reset.

Function
REQ-016 States: IDLE, WAKE, MEAS, DONE; encoding is free.
REQ-017 IDLE: core_rst=1, busy=0; start=1 -> WAKE next cycle, ovf cleared.
REQ-018 WAKE: core_rst=0; a cycle counter counts SETTLE cycles, then -> MEAS with the event counter and window counter zeroed.
REQ-019 MEAS: each cycle with src_ev=1 increments the event counter; snk_ev increments a total counter; simultaneous src_ev and snk_ev increment both.
REQ-020 Event and total counters saturate at all-ones; a saturating increment sets ovf.
REQ-021 MEAS lasts exactly WIN cycles; events on the first cycle through the WIN-th cycle inclusive are counted; the next edge loads result and enters DONE.
REQ-022 DONE: result_valid=1, result stable; core_rst stays 0; events arriving in DONE are ignored.
REQ-023 Handshake in DONE: with cont=1 -> MEAS (no WAKE), counters zeroed; with cont=0 -> IDLE.
REQ-024 result_valid deasserts on the cycle after the handshake; an unaccepted result stalls the sequencer in DONE indefinitely and is never overwritten.
REQ-025 start outside IDLE is ignored; cont is sampled only at the DONE handshake.
REQ-026 Latency start -> first counted cycle = 1 + SETTLE cycles; start -> result_valid = 1 + SETTLE + WIN cycles (single-window build).

Reset
REQ-027 Asynchronous reset, at any time including mid-MEAS or DONE, forces state IDLE, core_rst=1, busy=0, result=0, result_valid=0, ovf=0, all counters 0.
REQ-028 The first start is accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro TMP_MEAS_SEQ_AVG_EN: when defined, one measurement is four back-to-back WIN windows (no WAKE between them) summed in a CNT_W+2 accumulator and result = sum >> 2; ovf is set if any window count saturates.
REQ-030 Without TMP_MEAS_SEQ_AVG_EN, one measurement is a single window, result = window count, and no accumulator exists.

Verification
REQ-031 Reset then start with SETTLE=12, WIN=255, src_ev on every 3rd MEAS cycle -> result_valid at cycle 268 after start, result=85, ovf=0.
REQ-032 src_ev held high for all of MEAS with WIN=300, CNT_W=8 -> result=255, ovf=1; ovf clears on the next start accepted in IDLE.
REQ-033 cont=1, result_ready low for 50 cycles after result_valid -> result stable, busy=1, no new window; ready=1 -> valid drops next cycle, MEAS restarts without WAKE.
REQ-034 reset asserted mid-MEAS -> same cycle core_rst=1, result_valid=0, result=0; the next start gives a full WAKE+MEAS sequence.
REQ-035 start pulsed during WAKE and during DONE -> ignored, no extra measurement; src_ev and snk_ev simultaneous every cycle -> result=min(WIN,255).
REQ-036 With TMP_MEAS_SEQ_AVG_EN, window counts 100,101,102,103 -> result=101, and result_valid comes 3*WIN cycles later than in the single-window build.

Source files
------------

// File: rtl/tmp_meas_seq.sv
// Temperature-sensor measurement sequencer: wakes the core, counts source decisions over a window, hands off the result.
// Define TMP_MEAS_SEQ_AVG_EN to average four back-to-back windows per measurement.
module tmp_meas_seq #(
    parameter int unsigned SETTLE = 12,
    parameter int unsigned WIN    = 255,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cont,
    input  logic             src_ev,
    input  logic             snk_ev,
    output logic             core_rst,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             ovf
);

    localparam int unsigned SET_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam int unsigned SET_W    = (SET_LAST > 0) ? $clog2(SET_LAST + 1) : 1;
    localparam int unsigned WIN_W    = 16;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAKE,
        MEAS,
        DONE
    } state_t;

    state_t           state_q, state_nx;
    logic [SET_W-1:0] set_q, set_nx;
    logic [WIN_W-1:0] win_q, win_nx;
    logic [CNT_W-1:0] ev_q, ev_nx, ev_add;
    logic [CNT_W-1:0] tot_q, tot_nx, tot_add;
    logic [CNT_W-1:0] res_nx;
    logic             ovf_nx;
    logic             clr_win;
`ifdef TMP_MEAS_SEQ_AVG_EN
    logic [CNT_W+1:0] acc_q, acc_nx, acc_sum;
    logic [1:0]       idx_q, idx_nx;
`endif

    // Next-state and datapath update
    always_comb begin
        state_nx = state_q;
        set_nx   = set_q;
        win_nx   = win_q;
        ev_nx    = ev_q;
        tot_nx   = tot_q;
        ev_add   = ev_q;
        tot_add  = tot_q;
        res_nx   = result;
        ovf_nx   = ovf;
        clr_win  = 1'b0;
`ifdef TMP_MEAS_SEQ_AVG_EN
        acc_nx   = acc_q;
        idx_nx   = idx_q;
        acc_sum  = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_nx = WAKE;
                    set_nx   = '0;
                    ovf_nx   = 1'b0;
                end
            end
            WAKE: begin
                if (set_q == SET_W'(SET_LAST)) begin
                    state_nx = MEAS;
                    clr_win  = 1'b1;
                end else begin
                    set_nx = set_q + 1'b1;
                end
            end
            MEAS: begin
                // A clipped increment is what marks overflow
                if (src_ev) begin
                    if (ev_q == CNT_MAX) ovf_nx = 1'b1;
                    else                 ev_add = ev_q + 1'b1;
                end
                if (snk_ev) begin
                    if (tot_q == CNT_MAX) ovf_nx  = 1'b1;
                    else                  tot_add = tot_q + 1'b1;
                end
                ev_nx  = ev_add;
                tot_nx = tot_add;
                win_nx = win_q + 1'b1;
                if (win_q == WIN_LAST) begin
                    win_nx = '0;
`ifdef TMP_MEAS_SEQ_AVG_EN
                    acc_sum = acc_q + (CNT_W+2)'(ev_add);
                    if (idx_q == 2'd3) begin
                        res_nx   = CNT_W'(acc_sum >> 2);
                        state_nx = DONE;
                    end else begin
                        acc_nx = acc_sum;
                        idx_nx = idx_q + 1'b1;
                        ev_nx  = '0;
                        tot_nx = '0;
                    end
`else
                    res_nx   = ev_add;
                    state_nx = DONE;
`endif
                end
            end
            DONE: begin
                if (result_ready) begin
                    if (cont) begin
                        state_nx = MEAS;
                        clr_win  = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (clr_win) begin
            win_nx = '0;
            ev_nx  = '0;
            tot_nx = '0;
`ifdef TMP_MEAS_SEQ_AVG_EN
            acc_nx = '0;
            idx_nx = '0;
`endif
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            set_q        <= '0;
            win_q        <= '0;
            ev_q         <= '0;
            tot_q        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            ovf          <= 1'b0;
            core_rst     <= 1'b1;
            busy         <= 1'b0;
`ifdef TMP_MEAS_SEQ_AVG_EN
            acc_q        <= '0;
            idx_q        <= '0;
`endif
        end else begin
            state_q      <= state_nx;
            set_q        <= set_nx;
            win_q        <= win_nx;
            ev_q         <= ev_nx;
            tot_q        <= tot_nx;
            result       <= res_nx;
            result_valid <= (state_nx == DONE);
            ovf          <= ovf_nx;
            core_rst     <= (state_nx == IDLE);
            busy         <= (state_nx != IDLE);
`ifdef TMP_MEAS_SEQ_AVG_EN
            acc_q        <= acc_nx;
            idx_q        <= idx_nx;
`endif
        end
    end

endmodule
